// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, in-flight PC queue and 2-entry {pc, inst} FIFO.
// Define FETCH_BYPASS_EN to forward a kept response to decode in the same cycle.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc
);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    logic [31:0] pc_q;
    logic [1:0]  infl_q;
    logic [1:0]  disc_q;
    logic [1:0]  fcnt_q;
    logic [31:0] ipc0_q;
    logic [31:0] ipc1_q;
    entry_t      f0_q;
    entry_t      f1_q;

    logic        can_req;
    logic        accept;
    logic        resp_ok;
    logic        keep;
    logic        push;
    logic        pop_f;
    entry_t      resp_ent;
    entry_t      head;
    logic [1:0]  infl_n;
    logic [1:0]  qc;
    logic [31:0] ipc0_n;
    logic [31:0] ipc1_n;
    logic [1:0]  ec;
    logic [1:0]  fcnt_n;
    entry_t      f0_n;
    entry_t      f1_n;
    logic [31:0] redir_tgt;
    logic [1:0]  unused_redir_lsb;

    assign redir_tgt        = {redirect_pc[31:2], 2'b00};
    assign unused_redir_lsb = redirect_pc[1:0];

    // Request gating, handshake qualification and output selection
    always_comb begin
        can_req  = ({1'b0, infl_q} + {1'b0, fcnt_q}) < 3'd2;
        imem_req_valid = can_req & ~redirect_valid & ~rst;
        imem_addr      = rst ? RESET_PC : pc_q;
        accept   = imem_req_valid & imem_req_ready;
        resp_ok  = imem_resp_valid & (infl_q != 2'd0) & ~rst;
        keep     = resp_ok & (disc_q == 2'd0) & ~redirect_valid;
        resp_ent = '{pc: ipc0_q, inst: imem_resp_data};
`ifdef FETCH_BYPASS_EN
        head     = (fcnt_q != 2'd0) ? f0_q : resp_ent;
        if_valid = ~rst & ((fcnt_q != 2'd0) | keep);
        push     = keep & ~((fcnt_q == 2'd0) & if_ready);
        pop_f    = if_valid & if_ready & (fcnt_q != 2'd0);
`else
        head     = f0_q;
        if_valid = ~rst & (fcnt_q != 2'd0);
        push     = keep;
        pop_f    = if_valid & if_ready;
`endif
        if_inst  = rst ? 32'h0 : head.inst;
        if_pc    = rst ? 32'h0 : head.pc;
    end

    // Next-state of in-flight PC queue and decode FIFO
    always_comb begin
        infl_n = infl_q + {1'b0, accept} - {1'b0, resp_ok};
        qc     = infl_q - {1'b0, resp_ok};
        ipc0_n = resp_ok ? ipc1_q : ipc0_q;
        ipc1_n = ipc1_q;
        if (accept) begin
            if (qc == 2'd0) ipc0_n = pc_q;
            else            ipc1_n = pc_q;
        end
        ec   = fcnt_q - {1'b0, pop_f};
        f0_n = pop_f ? f1_q : f0_q;
        f1_n = f1_q;
        if (push) begin
            if (ec == 2'd0) f0_n = resp_ent;
            else            f1_n = resp_ent;
        end
        fcnt_n = ec + {1'b0, push};
    end

    // State update; redirect flushes the FIFO and marks in-flight responses stale
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q   <= RESET_PC;
            infl_q <= 2'd0;
            disc_q <= 2'd0;
            fcnt_q <= 2'd0;
            ipc0_q <= 32'h0;
            ipc1_q <= 32'h0;
            f0_q   <= '0;
            f1_q   <= '0;
        end else begin
            infl_q <= infl_n;
            ipc0_q <= ipc0_n;
            ipc1_q <= ipc1_n;
            f0_q   <= f0_n;
            f1_q   <= f1_n;
            if (redirect_valid) begin
                pc_q   <= redir_tgt;
                disc_q <= infl_n;
                fcnt_q <= 2'd0;
            end else begin
                if (accept) pc_q <= pc_q + 32'd4;
                if (resp_ok && disc_q != 2'd0) disc_q <= disc_q - 2'd1;
                fcnt_q <= fcnt_n;
            end
        end
    end

endmodule
